// File: rtl/led_pattern_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : led_pattern_gen_if
//  Description : Control/status bundle for the LED pattern generator.
//                The master loads mode/pattern/duty and watches the LEDs;
//                the slave (the generator) drives the LEDs and the tick.
//  Revision    : 1.0 - initial release
// ============================================================================
interface led_pattern_gen_if #(
    parameter int N_LEDS   = 6,
    parameter int PWM_BITS = 4
) ();
    logic                load_i;
    logic [1:0]          mode_i;
    logic [N_LEDS-1:0]   pattern_i;
    logic [PWM_BITS-1:0] duty_i;
    logic [N_LEDS-1:0]   led_o;
    logic                tick_o;

    modport master (
        output load_i, mode_i, pattern_i, duty_i,
        input  led_o, tick_o
    );

    modport slave (
        input  load_i, mode_i, pattern_i, duty_i,
        output led_o, tick_o
    );
endinterface
`default_nettype wire

// File: rtl/led_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module      : led_pattern_gen
//  Description : Multi-channel LED driver. A prescaler produces a pattern
//                tick every FREQ clocks; on each tick a binary counter and a
//                bouncing one-hot scanner advance. The loaded mode selects
//                static, count, scan or PWM-dimmed static onto the LEDs.
//  Revision    : 1.0 - initial release
// ============================================================================
module led_pattern_gen #(
    parameter int N_LEDS   = 6,
    parameter int FREQ     = 10,
    parameter int PWM_BITS = 4
) (
    input  wire logic clk_i,
    input  wire logic rstn_i,
    led_pattern_gen_if.slave bus
);

    localparam int                 c_PRESC_W     = (FREQ > 1) ? $clog2(FREQ) : 1;
    localparam logic [c_PRESC_W-1:0] c_PRESC_MAX = c_PRESC_W'(FREQ - 1);
    localparam logic [N_LEDS-1:0]  c_SCAN_INIT   = N_LEDS'(1);

    localparam logic [1:0] c_MODE_STATIC = 2'd0;
    localparam logic [1:0] c_MODE_COUNT  = 2'd1;
    localparam logic [1:0] c_MODE_SCAN   = 2'd2;
    localparam logic [1:0] c_MODE_PWM    = 2'd3;

    logic [1:0]           mode_q,    mode_d;
    logic [N_LEDS-1:0]    pattern_q, pattern_d;
    logic [PWM_BITS-1:0]  duty_q,    duty_d;
    logic [c_PRESC_W-1:0] presc_q,   presc_d;
    logic [N_LEDS-1:0]    cnt_q,     cnt_d;
    logic [N_LEDS-1:0]    scan_q,    scan_d;
    logic                 dir_q,     dir_d;
    logic [PWM_BITS-1:0]  pwm_q,     pwm_d;
    logic [N_LEDS-1:0]    led_q,     led_d;
    logic                 tick_q,    tick_d;

    logic                 w_advance;
    logic                 w_pwm_on;
    logic [N_LEDS-1:0]    w_scan_shift;
    logic                 w_dir_shift;

    // Next scanner position: a single LED cannot move, otherwise shift one
    // step and turn around as soon as an end bit is reached, so the endpoint
    // is shown only once per bounce.
    if (N_LEDS == 1) begin : g_scan_single
        assign w_scan_shift = scan_q;
        assign w_dir_shift  = 1'b1;
    end else begin : g_scan_multi
        assign w_scan_shift = dir_q ? {scan_q[N_LEDS-2:0], 1'b0}
                                    : {1'b0, scan_q[N_LEDS-1:1]};
        assign w_dir_shift  = dir_q ? ~w_scan_shift[N_LEDS-1]
                                    :  w_scan_shift[0];
    end

    // Next-state: prescaler, tick, pattern sources, load override and the
    // output select (which looks at the current registers, giving one edge
    // of latency from any state change to the pins).
    always_comb begin
        mode_d    = mode_q;
        pattern_d = pattern_q;
        duty_d    = duty_q;
        presc_d   = presc_q;
        cnt_d     = cnt_q;
        scan_d    = scan_q;
        dir_d     = dir_q;
        pwm_d     = pwm_q + PWM_BITS'(1);
        led_d     = '0;

        w_advance = (presc_q == c_PRESC_MAX);
        w_pwm_on  = (pwm_q < duty_q);
        tick_d    = w_advance;

        if (w_advance) begin
            presc_d = '0;
            cnt_d   = cnt_q + N_LEDS'(1);
            scan_d  = w_scan_shift;
            dir_d   = w_dir_shift;
        end else begin
            presc_d = presc_q + c_PRESC_W'(1);
        end

        // A load restarts every sequence and swallows a coincident tick.
        if (bus.load_i) begin
            mode_d    = bus.mode_i;
            pattern_d = bus.pattern_i;
            duty_d    = bus.duty_i;
            presc_d   = '0;
            cnt_d     = '0;
            pwm_d     = '0;
            scan_d    = c_SCAN_INIT;
            dir_d     = 1'b1;
            tick_d    = 1'b0;
        end

        case (mode_q)
            c_MODE_STATIC: led_d = pattern_q;
            c_MODE_COUNT:  led_d = cnt_q;
            c_MODE_SCAN:   led_d = scan_q;
            c_MODE_PWM:    led_d = pattern_q & {N_LEDS{w_pwm_on}};
            default:       led_d = '0;
        endcase
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            mode_q    <= c_MODE_STATIC;
            pattern_q <= '0;
            duty_q    <= '0;
            presc_q   <= '0;
            cnt_q     <= '0;
            scan_q    <= c_SCAN_INIT;
            dir_q     <= 1'b1;
            pwm_q     <= '0;
            led_q     <= '0;
            tick_q    <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            pattern_q <= pattern_d;
            duty_q    <= duty_d;
            presc_q   <= presc_d;
            cnt_q     <= cnt_d;
            scan_q    <= scan_d;
            dir_q     <= dir_d;
            pwm_q     <= pwm_d;
            led_q     <= led_d;
            tick_q    <= tick_d;
        end
    end

    assign bus.led_o  = led_q;
    assign bus.tick_o = tick_q;

endmodule
`default_nettype wire

// File: doc/led_pattern_gen.md
# led_pattern_gen

Parametrised multi-channel LED driver that generates static, binary-count, bouncing-scan and PWM-dimmed patterns from a programmable clock-divided tick. It is the successor of the fixed blinker in the board top: the top instantiates it between the system clock/reset and the board LED pins. Mode, pattern and duty are loaded through a single-cycle load strobe.

## Interface

- `N_LEDS`, default 6: number of LED channels; must be ≥ 1.
- `FREQ`, default 10: clock cycles per pattern tick; must be ≥ 1.
- `PWM_BITS`, default 4: width of the PWM counter and duty value; must be ≥ 1.

Ports:

- `clk_i`  in  1: system clock; all state is updated on the rising edge.
- `rstn_i`  in  1: reset, asynchronous, active-low.
- `load_i`  in  1: when high at a clock edge, captures `mode_i`, `pattern_i` and `duty_i`.
- `mode_i`  in  2: 0 STATIC, 1 COUNT, 2 SCAN, 3 PWM.
- `pattern_i`  in  N_LEDS: static pattern and PWM enable mask.
- `duty_i`  in  PWM_BITS: PWM on-threshold.
- `led_o`  out  N_LEDS: registered LED drive, 1 = on.
- `tick_o`  out  1: registered one-cycle pulse marking each pattern tick.

## Operation

Internal registers:

- `mode_q` (2), `pattern_q` (N_LEDS), `duty_q` (PWM_BITS).
- `presc_q`: 0..FREQ-1, width $clog2(FREQ), minimum 1.
- `cnt_q` (N_LEDS), `scan_q` (N_LEDS, one-hot), `dir_q` (1 = moving toward the MSB).
- `pwm_q` (PWM_BITS).

Reset (asynchronous, while `rstn_i` = 0):

- `led_o` = 0, `tick_o` = 0.
- `mode_q` = STATIC, `pattern_q` = 0, `duty_q` = 0.
- `presc_q` = 0, `cnt_q` = 0, `pwm_q` = 0.
- `scan_q` = 1 (bit 0), `dir_q` = 1.

Prescaler:

- `presc_q` increments every cycle.
- When `presc_q` == FREQ-1 it wraps to 0, and that same edge sets `tick_o` = 1 and is an "advance edge". `tick_o` = 0 otherwise.
- FREQ = 1 gives a tick on every cycle.

On an advance edge:

- `cnt_q` ← `cnt_q` + 1, modulo 2^N_LEDS; all-ones wraps to 0.
- SCAN: `scan_q` shifts one position in direction `dir_q`.
  - Reaching bit N_LEDS-1 clears `dir_q`; reaching bit 0 sets it.
  - So the sequence is 0,1,…,N-1,N-2,…,1,0,1,… with no repeated endpoint.
  - N_LEDS = 1: `scan_q` stays at 1.
- `cnt_q` and `scan_q` advance in every mode, but only the selected mode is visible on `led_o`.

PWM counter:

- `pwm_q` increments every clock (not every tick) and wraps modulo 2^PWM_BITS.
- PWM "on" = (`pwm_q` < `duty_q`), unsigned compare.
- `duty_q` = 0 is always off. Maximum duty is on for 2^PWM_BITS − 1 of every 2^PWM_BITS cycles.

Output select, registered into `led_o` every edge from the current register values:

- STATIC → `pattern_q`.
- COUNT → `cnt_q`.
- SCAN → `scan_q`.
- PWM → `pattern_q` masked by the PWM "on" bit replicated across all channels.

Load (`load_i` = 1 at an edge):

- `mode_q`, `pattern_q` and `duty_q` take their inputs.
- `presc_q`, `cnt_q` and `pwm_q` are cleared; `scan_q` = 1 and `dir_q` = 1.
- `tick_o` is forced to 0 on that edge.
- Load has priority over a coincident tick: that tick is dropped, with no advance.
- Back-to-back loads are legal; each restarts the sequence.

## Timing

- Output latency: `led_o` at edge k+1 reflects the register values held after edge k.
  - A load at edge L shows the new STATIC pattern at edge L+1.
  - A count advance at edge T shows on `led_o` at edge T+1.
- After reset release or a load, the first `tick_o` pulse is at edge FREQ (counting the first active edge as 1). Pulses then repeat every FREQ edges, with exactly one cycle high.
- A reset assertion mid-operation immediately forces every output and register to its reset value, independent of the clock.
- Inputs are sampled only at edges where `load_i` = 1. Between loads, `mode_i`, `pattern_i` and `duty_i` may change freely.

## Test plan

Bench defaults: N_LEDS = 6, FREQ = 10, PWM_BITS = 4.

- **Reset, idle.** Hold reset 2 cycles then release, no load → `led_o` = 0 throughout, `tick_o` pulses every 10 cycles, first pulse at edge 10.
- **STATIC.** Load STATIC with `pattern_i` = 6'b101101 → `led_o` = 6'b101101 one edge later and stays there across ticks.
- **COUNT.** Load COUNT → `led_o` steps 0,1,2,…,63,0 at one step per 10 cycles. Wrap 63→0 occurs at tick 64. Each `led_o` change follows its `tick_o` pulse by exactly one edge.
- **SCAN.** Load SCAN → `led_o` = 000001, 000010, …, 100000, 010000, …, 000001, 000010. The bounce has no repeated endpoints.
- **PWM.**
  - `pattern_i` = 6'b111111, `duty_i` = 5 → `led_o` all-ones for 5 of every 16 cycles, periodic.
  - `duty_i` = 0 → always 0.
  - `duty_i` = 15 → off exactly 1 cycle in 16.
- **Load collision and async reset.**
  - Load COUNT exactly on the edge where `presc_q` = 9 → no tick pulse, `cnt_q` stays 0, next tick 10 edges later.
  - Assert `rstn_i` low mid-cycle during COUNT at value 37 → `led_o` and `tick_o` go to 0 before the next clock edge.
